cnn_conv_sequencer: RTL and testbench
=====================================

# cnn_conv_sequencer

Control block for the 2-filter 3x3 convolution stage of the Tiny Tapeout CNN. It accepts a 64-pixel 8x8 frame over a valid/ready stream and generates write addresses for the image buffer. It then walks the 36 valid-convolution output positions and the 9 kernel taps, driving buffer read addresses and multiply-accumulate enables for the conv datapath. Each finished output pixel is handed downstream with a valid/ready handshake that can stall the walk.

## Interface
- IMG_W, 8, image width and height in pixels (square frame)
- K, 3, kernel size (K*K taps per output)
- OUT_W, IMG_W-K+1 = 6, output width and height; no padding, stride 1
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock, synchronous, active-low
- start  in  1  begin a frame; sampled only in IDLE
- pix_valid  in  1  input pixel strobe (pixel data goes straight to the buffer)
- pix_ready  out  1  high throughout LOAD
- buf_wr_en  out  1  equals pix_valid && pix_ready
- buf_wr_addr  out  6  raster index of the pixel being written
- rd_en  out  1  registered; buffer read issue
- rd_addr  out  6  registered; (oy+ky)*IMG_W + (ox+kx)
- mac_en  out  1  rd_en delayed 1 cycle (buffer data valid)
- mac_clr  out  1  with mac_en on tap 0: accumulator loads instead of adds
- mac_last  out  1  with mac_en on tap 8: datapath latches result register
- tap_idx  out  4  tap 0..8 aligned with mac_en; weight index = f*9 + tap_idx for filter f
- res_valid  out  1  result register holds a finished output pixel
- res_x, res_y  out  3 each  coordinates of that pixel
- out_ready  in  1  downstream accepts the result
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at frame completion

## Operation
- States: IDLE, LOAD, CONV, DRAIN, DONE.
- **Reset.** Every output and counter is 0 and the state is IDLE. Reset wins over all other inputs in any state, including mid-LOAD or mid-CONV. No partial result survives.
- **IDLE**
  - start=1 moves to LOAD and clears all counters.
  - pix_valid is ignored.
- **LOAD**
  - Each accepted pixel writes to load_cnt, then load_cnt increments.
  - Acceptance of pixel 63 moves to CONV on the next cycle.
  - pix_valid gaps are allowed; there is no timeout.
  - start is ignored while busy.
- **CONV issue rule.** Each cycle, one tap is issued unless stalled. Stall condition: res_valid && !out_ready.
- **CONV counter order.**
  - kx fastest, then ky; both run 0..K-1.
  - Then ox, then oy; both run 0..OUT_W-1.
  - Counters wrap to 0 at the end of their range, carrying into the next counter.
- **CONV exit.** Issuing tap 8 of position (5,5) moves to DRAIN.
- **Filters.** Both filters are computed in parallel by the datapath; the sequencer serves both with one tap_idx.
- **Result handshake.**
  - mac_last at cycle t sets res_valid at t+1, with res_x/res_y equal to that position.
  - res_valid clears on out_ready.
  - The stall rule guarantees a new mac_last never overwrites an unaccepted result.
- **DRAIN.** Waits until the pipeline stage is empty and the final result is accepted, then moves to DONE.
- **DONE.** done=1 for one cycle, then IDLE.
- **Arithmetic.** rd_addr uses unsigned 6-bit arithmetic, maximum 7*8+7 = 63. No out-of-range address is ever issued.

## Timing
- Load: a minimum of 64 cycles with continuous pix_valid.
- Stage alignment: rd_en at t gives mac_en/tap_idx/mac_clr/mac_last at t+1. A stalled issue gives mac_en=0 the next cycle.
- First result: first CONV cycle is C0; mac_clr at C0+1, mac_last at C0+9, res_valid at C0+10.
- Unstalled frame: results every 9 cycles; last res_valid at C0+325; done the cycle after the final handshake.
- Stall of N cycles: adds exactly N cycles to all later events.

## Structure
- Shared package cnn_pkg holds:
  - IMG_W, K, OUT_W;
  - the seq_state_t enum;
  - the address-width constant, $clog2(IMG_W*IMG_W).
- One sub-module, conv_addr_gen, contains:
  - the kx/ky/ox/oy counters with the advance enable;
  - the registered rd_addr;
  - last-tap and last-position flags.
- The top-level FSM, the delay stage and the result handshake stay in cnn_conv_sequencer.

## Test plan
- **Reset mid-frame.** rst_n=0 for 1 cycle at CONV pixel (2,3) -> next cycle state IDLE, busy=0, res_valid=0, rd_en=0; pix_valid then ignored until start.
- **Load.** start, then 64 pixels with pix_valid toggling 1/0 -> buf_wr_addr 0..63 in order, exactly 64 writes, CONV entered after the 64th.
- **Address sequence.** out_ready=1 -> position (0,0) rd_addr 0,1,2,8,9,10,16,17,18. Position (5,5) rd_addr 45,46,47,53,54,55,61,62,63. mac_clr only on tap 0, mac_last only on tap 8.
- **Throughput.** out_ready=1 -> 36 res_valid pulses, 9 cycles apart, coordinates (0,0)..(5,5) raster order; done 1 cycle after the last.
- **Backpressure.** out_ready=0 for 20 cycles after the first res_valid -> res_x/res_y held at (0,0), no rd_en during the stall, second result delayed by exactly 20 cycles, no result lost.
- **Start while busy.** start pulsed during LOAD and CONV -> ignored; a new frame starts only after done and a fresh start in IDLE.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: frame geometry, state encoding and
// address helper shared by the conv sequencer.
package cnn_pkg;

    localparam int IMG_W  = 8;
    localparam int K      = 3;
    localparam int OUT_W  = IMG_W - K + 1;
    localparam int NPIX   = IMG_W * IMG_W;
    localparam int NTAP   = K * K;
    localparam int ADDR_W = $clog2(IMG_W * IMG_W);
    localparam int KW     = $clog2(K);
    localparam int PW     = $clog2(OUT_W);
    localparam int TW     = $clog2(NTAP);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CONV  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    function automatic logic [ADDR_W-1:0] pix_addr(
        input logic [ADDR_W-1:0] row,
        input logic [ADDR_W-1:0] col
    );
        return (row * ADDR_W'(IMG_W)) + col;
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: kernel/position walk counters and
// the registered image-buffer read port.
module conv_addr_gen
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              adv,
    output logic              last_tap,
    output logic              last_pos,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [TW-1:0]     rd_tap,
    output logic [PW-1:0]     rd_x,
    output logic [PW-1:0]     rd_y
);

    logic [KW-1:0]     kx;
    logic [KW-1:0]     ky;
    logic [PW-1:0]     ox;
    logic [PW-1:0]     oy;
    logic              kx_end;
    logic              ox_end;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic [TW-1:0]     tap;

    assign kx_end   = (kx == KW'(K - 1));
    assign last_tap = kx_end && (ky == KW'(K - 1));
    assign ox_end   = (ox == PW'(OUT_W - 1));
    assign last_pos = ox_end && (oy == PW'(OUT_W - 1));

    assign row = ADDR_W'(oy) + ADDR_W'(ky);
    assign col = ADDR_W'(ox) + ADDR_W'(kx);
    assign tap = (TW'(ky) * TW'(K)) + TW'(kx);

    // walk counters: kx fastest, then ky, ox, oy
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            kx <= '0;
            ky <= '0;
            ox <= '0;
            oy <= '0;
        end else if (adv) begin
            kx <= kx_end ? '0 : kx + 1'b1;
            if (kx_end) begin
                ky <= last_tap ? '0 : ky + 1'b1;
                if (last_tap) begin
                    ox <= ox_end ? '0 : ox + 1'b1;
                    if (ox_end) begin
                        oy <= last_pos ? '0 : oy + 1'b1;
                    end
                end
            end
        end
    end

    // registered read issue with its tap and position tags
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
            rd_tap  <= '0;
            rd_x    <= '0;
            rd_y    <= '0;
        end else begin
            rd_en <= adv;
            if (adv) begin
                rd_addr <= pix_addr(row, col);
                rd_tap  <= tap;
                rd_x    <= ox;
                rd_y    <= oy;
            end
        end
    end

endmodule

// File: rtl/cnn_conv_sequencer.sv
// cnn_conv_sequencer: frame load, 3x3 tap walk,
// MAC control and result handshake for the conv stage.
module cnn_conv_sequencer
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              mac_en,
    output logic              mac_clr,
    output logic              mac_last,
    output logic [TW-1:0]     tap_idx,
    output logic              res_valid,
    output logic [PW-1:0]     res_x,
    output logic [PW-1:0]     res_y,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    seq_state_t        state;
    seq_state_t        state_n;
    logic [ADDR_W-1:0] load_cnt;
    logic              clr;
    logic              adv;
    logic              stall;
    logic              last_tap;
    logic              last_pos;
    logic [TW-1:0]     rd_tap;
    logic [PW-1:0]     rd_x;
    logic [PW-1:0]     rd_y;
    logic [PW-1:0]     mac_x;
    logic [PW-1:0]     mac_y;

    assign pix_ready   = (state == ST_LOAD);
    assign buf_wr_en   = pix_valid && pix_ready;
    assign buf_wr_addr = load_cnt;
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign stall       = res_valid && !out_ready;

    conv_addr_gen u_addr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .adv      (adv),
        .last_tap (last_tap),
        .last_pos (last_pos),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_tap   (rd_tap),
        .rd_x     (rd_x),
        .rd_y     (rd_y)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // next state, counter clear and tap advance
    always_comb begin
        state_n = state;
        adv     = 1'b0;
        clr     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_LOAD;
                    clr     = 1'b1;
                end
            end
            ST_LOAD: begin
                if (buf_wr_en &&
                    load_cnt == ADDR_W'(NPIX - 1)) begin
                    state_n = ST_CONV;
                    adv     = 1'b1;
                end
            end
            ST_CONV: begin
                if (!stall) begin
                    adv = 1'b1;
                    if (last_tap && last_pos) begin
                        state_n = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!rd_en && !mac_en &&
                    res_valid && out_ready) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // raster write pointer for the incoming frame
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            load_cnt <= '0;
        end else if (buf_wr_en) begin
            load_cnt <= load_cnt + 1'b1;
        end
    end

    // buffer-data stage: MAC controls one cycle after the read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mac_en   <= 1'b0;
            mac_clr  <= 1'b0;
            mac_last <= 1'b0;
            tap_idx  <= '0;
            mac_x    <= '0;
            mac_y    <= '0;
        end else begin
            mac_en   <= rd_en;
            mac_clr  <= rd_en && (rd_tap == '0);
            mac_last <= rd_en && (rd_tap == TW'(NTAP - 1));
            tap_idx  <= rd_tap;
            mac_x    <= rd_x;
            mac_y    <= rd_y;
        end
    end

    // result register and downstream handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_x     <= '0;
            res_y     <= '0;
        end else if (mac_last) begin
            res_valid <= 1'b1;
            res_x     <= mac_x;
            res_y     <= mac_y;
        end else if (out_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cnn_conv_sequencer.sv
// tb_cnn_conv_sequencer: directed frames with write and
// result scoreboards for the conv sequencer.
module tb_cnn_conv_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       pix_valid;
    logic       pix_ready;
    logic       buf_wr_en;
    logic [5:0] buf_wr_addr;
    logic       rd_en;
    logic [5:0] rd_addr;
    logic       mac_en;
    logic       mac_clr;
    logic       mac_last;
    logic [3:0] tap_idx;
    logic       res_valid;
    logic [2:0] res_x;
    logic [2:0] res_y;
    logic       out_ready;
    logic       busy;
    logic       done;

    cnn_conv_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .buf_wr_en   (buf_wr_en),
        .buf_wr_addr (buf_wr_addr),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .mac_en      (mac_en),
        .mac_clr     (mac_clr),
        .mac_last    (mac_last),
        .tap_idx     (tap_idx),
        .res_valid   (res_valid),
        .res_x       (res_x),
        .res_y       (res_y),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int cyc = 0;
    int c0 = 0;
    int last_wr = 0;
    int first_rd = -1;
    int hs_cyc = -100;
    int done_cyc = -1;
    int done_cnt = 0;
    int wr_cnt = 0;
    int mt = 0;
    int mx = 0;
    int my = 0;
    int tap_d = 0;
    int bp_left = 0;
    bit mon_en = 0;
    bit bp_arm = 0;
    bit stall_win = 0;
    bit stall_prev = 0;
    bit res_d = 0;
    logic rd_en_d = 1'b0;

    int wq[$];
    int rq[$];
    int rises[$];

    int t00[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    int t55[9] = '{45, 46, 47, 53, 54, 55, 61, 62, 63};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, obs, exp);
        end
    endtask

    function automatic int eaddr(int x, int y, int t);
        return (y + t / 3) * 8 + x + t % 3;
    endfunction

    task automatic rst_model();
        mt = 0;
        mx = 0;
        my = 0;
        tap_d = 0;
        rd_en_d = 1'b0;
        stall_prev = 0;
        res_d = 0;
        bp_arm = 0;
        bp_left = 0;
        stall_win = 0;
        out_ready = 1'b1;
        wq.delete();
        rq.delete();
    endtask

    task automatic monitor();
        if (buf_wr_en) begin
            wr_cnt++;
            last_wr = cyc;
            if (wq.size() == 0) begin
                chk("wr_spurious", buf_wr_en, 0);
            end else begin
                chk("wr_addr", buf_wr_addr, wq.pop_front());
            end
        end
        chk("mac_en", mac_en, rd_en_d);
        chk("mac_clr", mac_clr, rd_en_d && tap_d == 0);
        chk("mac_last", mac_last, rd_en_d && tap_d == 8);
        if (mac_en) chk("tap_idx", tap_idx, tap_d);
        if (stall_prev) chk("rd_after_stall", rd_en, 0);
        if (rd_en) begin
            if (first_rd < 0) first_rd = cyc;
            chk("rd_addr", rd_addr, eaddr(mx, my, mt));
            if (mx == 0 && my == 0)
                chk("rd_p00", rd_addr, t00[mt]);
            if (mx == 5 && my == 5)
                chk("rd_p55", rd_addr, t55[mt]);
            tap_d = mt;
            mt++;
            if (mt == 9) begin
                mt = 0;
                mx++;
                if (mx == 6) begin
                    mx = 0;
                    my = (my == 5) ? 0 : my + 1;
                end
            end
        end
        rd_en_d = rd_en;
        stall_prev = res_valid && !out_ready;
        if (res_valid && !res_d) rises.push_back(cyc);
        res_d = res_valid;
        if (stall_win && res_valid) begin
            chk("hold_x", res_x, 0);
            chk("hold_y", res_y, 0);
        end
        if (res_valid && out_ready) begin
            hs_cyc = cyc;
            if (rq.size() == 0) begin
                chk("res_spurious", res_valid, 0);
            end else begin
                int e;
                e = rq.pop_front();
                chk("res_x", res_x, e % 8);
                chk("res_y", res_y, e / 8);
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (mon_en) monitor();
        @(posedge clk);
        #1;
        if (bp_arm && res_valid) begin
            out_ready = 1'b0;
            stall_win = 1;
            bp_left = 20;
            bp_arm = 0;
        end else if (bp_left > 0) begin
            bp_left--;
            if (bp_left == 0) begin
                out_ready = 1'b1;
                stall_win = 0;
            end
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pix_ready"}, pix_ready, 0);
        chk({tag, "_wr_en"}, buf_wr_en, 0);
        chk({tag, "_wr_addr"}, buf_wr_addr, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_mac_en"}, mac_en, 0);
        chk({tag, "_mac_clr"}, mac_clr, 0);
        chk({tag, "_mac_last"}, mac_last, 0);
        chk({tag, "_tap"}, tap_idx, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_x"}, res_x, 0);
        chk({tag, "_res_y"}, res_y, 0);
    endtask

    task automatic idle_gap();
        pix_valid = 1'b1;
        repeat (4) begin
            tick();
            chk("idle_busy", busy, 0);
        end
        pix_valid = 1'b0;
    endtask

    task automatic load_frame(input bit toggle);
        int i;
        bit ph;
        rises.delete();
        done_cnt = 0;
        wr_cnt = 0;
        first_rd = -1;
        hs_cyc = -100;
        done_cyc = -1;
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 6; x++)
                rq.push_back(y * 8 + x);
        start = 1'b1;
        tick();
        start = 1'b0;
        i = 0;
        ph = 0;
        while (i < 64) begin
            pix_valid = !(toggle && ph);
            if (pix_valid) begin
                wq.push_back(i);
                i++;
            end
            ph = !ph;
            start = (i == 20);
            chk("pix_ready", pix_ready, 1);
            tick();
        end
        pix_valid = 1'b0;
        start = 1'b0;
        c0 = last_wr + 1;
    endtask

    task automatic run_frame(input bit toggle, input bit bp);
        load_frame(toggle);
        bp_arm = bp;
        for (int k = 0; k < 1000 && done_cnt == 0; k++) begin
            start = (k == 50);
            pix_valid = (k >= 100 && k < 110);
            tick();
        end
        start = 1'b0;
        pix_valid = 1'b0;
        bp_arm = 0;
        chk("idle_after_done", busy, 0);
        tick();
        chk("done_count", done_cnt, 1);
        chk("done_after_hs", done_cyc, hs_cyc + 1);
        chk("wr_count", wr_cnt, 64);
        chk("wr_left", wq.size(), 0);
        chk("res_left", rq.size(), 0);
        chk("first_rd", first_rd, c0);
        chk("res_count", rises.size(), 36);
        if (rises.size() == 36) begin
            chk("res_first", rises[0], c0 + 10);
            if (bp) begin
                chk("res_second", rises[1], c0 + 39);
                chk("res_last", rises[35], c0 + 345);
            end else begin
                chk("res_last", rises[35], c0 + 325);
                for (int j = 1; j < 36; j++)
                    chk("res_gap", rises[j] - rises[j-1], 9);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        pix_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        rst_model();
        mon_en = 1;
        check_idle("reset");
        idle_gap();

        run_frame(1, 0);
        idle_gap();

        run_frame(0, 1);
        idle_gap();

        load_frame(0);
        for (int k = 0; k < 184; k++) tick();
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        rst_model();
        check_idle("midrst");
        idle_gap();

        run_frame(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
